// File: rtl/rom_boot_loader_if.sv
// rom_boot_loader_if: bundles the SPI flash pins and the ROM write port of
// the boot loader.
//   AW     : ROM address width, must equal $clog2(KB*1024) of the loader
//   spiCs  : flash chip select, active low        (loader -> flash)
//   spiCk  : flash serial clock, SPI mode 0       (loader -> flash)
//   spiDo  : master-out data                      (loader -> flash)
//   spiDi  : master-in data                       (flash  -> loader)
//   a/d/w  : ROM write address, data, strobe      (loader -> ROM)
//   ready  : image fully written                  (loader -> system)
interface rom_boot_loader_if #(
  parameter int unsigned AW = 16
);
  logic          spiCs;
  logic          spiCk;
  logic          spiDo;
  logic          spiDi;
  logic [AW-1:0] a;
  logic [7:0]    d;
  logic          w;
  logic          ready;

  modport master (
    output spiCs, spiCk, spiDo, a, d, w, ready,
    input  spiDi
  );

  modport slave (
    input  spiCs, spiCk, spiDo, a, d, w, ready,
    output spiDi
  );
endinterface

// File: rtl/rom_boot_loader.sv
// rom_boot_loader: after reset, reads a KB KiB image from SPI flash starting
// at byte address OFFSET and writes it byte by byte into a ROM/RAM, then
// raises ready.
//   KB     : image size in KiB (N = KB*1024 bytes)
//   OFFSET : flash byte address of the first image byte
//   clock  : system clock, rising edge
//   reset  : synchronous, active high
//   bus    : rom_boot_loader_if.master (SPI pins, ROM write port, ready)
// Macro ROM_FAST_READ_EN: use FAST READ (0x0B) with 8 dummy bits instead of
// plain READ (0x03).
module rom_boot_loader #(
  parameter int unsigned KB     = 64,
  parameter logic [23:0] OFFSET = 24'h000000
) (
  input logic               clock,
  input logic               reset,
  rom_boot_loader_if.master bus
);
  localparam int unsigned N  = KB * 1024;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = AW + 1;

`ifdef ROM_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
`endif

  state_t        state;
  logic          phase;
  logic [4:0]    bit_cnt;
  logic [30:0]   tx;        // remaining opcode/address bits; zeros follow
  logic [7:0]    rx;
  logic [CW-1:0] byte_cnt;  // one extra bit so reaching N never wraps to 0

  logic          cs, ck, dout, wr, rdy;
  logic [AW-1:0] addr;
  logic [7:0]    data;

  logic [7:0]    rx_next;
  logic [CW-1:0] byte_next;
  logic          last_bit;

  always_comb begin
    rx_next   = {rx[6:0], bus.spiDi};
    byte_next = byte_cnt + 1'b1;
    last_bit  = 1'b0;
    case (state)
      CMD:     last_bit = (bit_cnt == 5'd7);
      ADDR:    last_bit = (bit_cnt == 5'd23);
`ifdef ROM_FAST_READ_EN
      DUMMY:   last_bit = (bit_cnt == 5'd7);
`endif
      DATA:    last_bit = (bit_cnt == 5'd7);
      default: last_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      tx       <= '0;
      rx       <= '0;
      byte_cnt <= '0;
      cs       <= 1'b1;
      ck       <= 1'b0;
      dout     <= 1'b0;
      addr     <= '0;
      data     <= '0;
      wr       <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      wr <= 1'b0;
      case (state)
        IDLE: begin
          state    <= CMD;
          cs       <= 1'b0;
          ck       <= 1'b0;
          phase    <= 1'b0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          dout     <= OPCODE[7];
          tx       <= {OPCODE[6:0], OFFSET};
        end
        DONE: begin
          rdy <= 1'b1;
        end
        default: begin
          if (!phase) begin
            ck    <= 1'b1;
            phase <= 1'b1;
          end else begin
            // End of a bit: sample spiDi and present the next MOSI bit in
            // the same edge, so bits and state changes run with no gaps.
            ck      <= 1'b0;
            phase   <= 1'b0;
            dout    <= tx[30];
            tx      <= {tx[29:0], 1'b0};
            bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
            if (state == DATA) rx <= rx_next;
            if (last_bit) begin
              case (state)
                CMD: state <= ADDR;
`ifdef ROM_FAST_READ_EN
                ADDR:  state <= DUMMY;
                DUMMY: state <= DATA;
`else
                ADDR: state <= DATA;
`endif
                DATA: begin
                  addr     <= byte_cnt[AW-1:0];
                  data     <= rx_next;
                  wr       <= 1'b1;
                  byte_cnt <= byte_next;
                  if (byte_next == CW'(N)) begin
                    state <= DONE;
                    cs    <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.spiCs = cs;
  assign bus.spiCk = ck;
  assign bus.spiDo = dout;
  assign bus.a     = addr;
  assign bus.d     = data;
  assign bus.w     = wr;
  assign bus.ready = rdy;
endmodule

// File: tb/tb_rom_boot_loader.sv
// tb_rom_boot_loader: drives rom_boot_loader (KB=1, OFFSET=24'h010000)
// against a byte-array SPI flash model and checks header bits, written
// image, ready latency, reset abort and per-clock protocol rules.
module tb_rom_boot_loader;
  localparam int unsigned KB  = 1;
  localparam int unsigned N   = KB * 1024;
  localparam int unsigned AW  = $clog2(N);
  localparam logic [23:0] OFF = 24'h010000;
`ifdef ROM_FAST_READ_EN
  localparam logic [7:0]  OPC = 8'h0B;
  localparam int unsigned HDR = 40;
  localparam logic [39:0] EXP_HDR = {OPC, OFF, 8'h00};
`else
  localparam logic [7:0]  OPC = 8'h03;
  localparam int unsigned HDR = 32;
  localparam logic [39:0] EXP_HDR = {8'h00, OPC, OFF};
`endif
  localparam int unsigned LAT = 16 * (HDR / 8 + N) + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rom_boot_loader_if #(.AW(AW)) bus ();

  rom_boot_loader #(.KB(KB), .OFFSET(OFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]    flash_mem [N];
  int unsigned   cyc = 0;
  int unsigned   fbits = 0;
  logic [39:0]   hdr_cap = '0;
  logic          dat_do_err = 1'b0;
  int unsigned   viol_ww = 0, viol_ckcs = 0, viol_rdy = 0;
  logic          w_prev = 1'b0, rdy_prev = 1'b0;
  logic [AW-1:0] wa_q [$];
  logic [7:0]    wd_q [$];
  int unsigned   ready_cyc = 0;
  logic          ready_seen = 1'b0;

  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  // Flash model plus protocol monitor, evaluated mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      hdr_cap    = '0;
      dat_do_err = 1'b0;
      ready_seen = 1'b0;
    end
    if (reset || bus.spiCs) begin
      fbits     = 0;
      bus.spiDi = 1'b0;
    end else if (!bus.spiCk) begin
      if (fbits >= HDR) begin
        int unsigned j;
        j = fbits - HDR;
        bus.spiDi = (j / 8 < N) ? flash_mem[j / 8][7 - (j % 8)] : 1'b0;
      end else begin
        bus.spiDi = 1'($urandom % 2);  // junk during command/address/dummy
      end
    end else begin
      if (fbits < HDR) hdr_cap = {hdr_cap[38:0], bus.spiDo};
      else if (bus.spiDo) dat_do_err = 1'b1;
      fbits++;
    end
    if (bus.w && w_prev) viol_ww++;
    if (bus.spiCs && bus.spiCk) viol_ckcs++;
    if (rdy_prev && !bus.ready && !reset) viol_rdy++;
    if (bus.w) begin
      wa_q.push_back(bus.a);
      wd_q.push_back(bus.d);
    end
    if (bus.ready && !ready_seen) begin
      ready_seen = 1'b1;
      ready_cyc  = cyc;
    end
    w_prev   = bus.w;
    rdy_prev = bus.ready;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic int count_bad_writes();
    int bad = 0;
    for (int k = 0; k < wa_q.size(); k++)
      if (wa_q[k] !== AW'(k) || wd_q[k] !== flash_mem[k]) bad++;
    return bad;
  endfunction

  task automatic clear_obs();
    wa_q.delete();
    wd_q.delete();
    viol_ww = 0; viol_ckcs = 0; viol_rdy = 0;
  endtask

  task automatic wait_ready(output bit to);
    to = 1'b1;
    for (int i = 0; i < LAT + 200; i++) begin
      tick();
      if (ready_seen) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic start_load();
    reset = 1'b1;
    tick();
    clear_obs();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    tests++; if (bus.spiCs !== 1'b1) begin fails++; $display("FAIL reset_spiCs got %b want 1", bus.spiCs); end
    tests++; if (bus.spiCk !== 1'b0) begin fails++; $display("FAIL reset_spiCk got %b want 0", bus.spiCk); end
    tests++; if (bus.spiDo !== 1'b0) begin fails++; $display("FAIL reset_spiDo got %b want 0", bus.spiDo); end
    tests++; if (bus.a !== '0) begin fails++; $display("FAIL reset_a got %h want 0", bus.a); end
    tests++; if (bus.d !== 8'h00) begin fails++; $display("FAIL reset_d got %h want 00", bus.d); end
    tests++; if (bus.w !== 1'b0) begin fails++; $display("FAIL reset_w got %b want 0", bus.w); end
    tests++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", bus.ready); end
  endtask

  task automatic test_random_load();
    bit to;
    int bad;
    for (int k = 0; k < N; k++) flash_mem[k] = 8'($urandom);
    start_load();
    wait_ready(to);
    bad = count_bad_writes();
    tests++; if (to) begin fails++; $display("FAIL rand_ready_timeout got none want ready by %0d", LAT); end
    tests++; if (hdr_cap !== EXP_HDR) begin fails++; $display("FAIL rand_header got %h want %h", hdr_cap, EXP_HDR); end
    tests++; if (ready_cyc != LAT) begin fails++; $display("FAIL rand_latency got %0d want %0d", ready_cyc, LAT); end
    tests++; if (wa_q.size() != N) begin fails++; $display("FAIL rand_write_count got %0d want %0d", wa_q.size(), N); end
    tests++; if (bad != 0) begin fails++; $display("FAIL rand_write_data got %0d bad writes want 0", bad); end
    tests++; if (dat_do_err !== 1'b0) begin fails++; $display("FAIL rand_data_mosi got %b want 0", dat_do_err); end
    tests++; if (viol_ww + viol_ckcs + viol_rdy != 0) begin fails++; $display("FAIL rand_protocol got ww=%0d ckcs=%0d rdy=%0d want 0", viol_ww, viol_ckcs, viol_rdy); end
  endtask

  task automatic test_done_quiet();
    int unsigned n0;
    n0 = wa_q.size();
    repeat (300) tick();
    tests++; if (wa_q.size() != n0) begin fails++; $display("FAIL done_writes got %0d want %0d", wa_q.size(), n0); end
    tests++; if (bus.spiCs !== 1'b1 || bus.spiCk !== 1'b0) begin fails++; $display("FAIL done_spi got cs=%b ck=%b want cs=1 ck=0", bus.spiCs, bus.spiCk); end
    tests++; if (bus.ready !== 1'b1 || viol_rdy != 0) begin fails++; $display("FAIL done_ready got %b falls=%0d want 1 falls=0", bus.ready, viol_rdy); end
  endtask

  task automatic test_alternating();
    bit to;
    int bad;
    for (int k = 0; k < N; k++) flash_mem[k] = (k % 2) ? 8'h5A : 8'hA5;
    start_load();
    wait_ready(to);
    bad = count_bad_writes();
    tests++; if (to) begin fails++; $display("FAIL alt_ready_timeout got none want ready by %0d", LAT); end
    tests++; if (hdr_cap !== EXP_HDR) begin fails++; $display("FAIL alt_header got %h want %h", hdr_cap, EXP_HDR); end
    tests++; if (wa_q.size() != N || bad != 0) begin fails++; $display("FAIL alt_writes got count=%0d bad=%0d want count=%0d bad=0", wa_q.size(), bad, N); end
    tests++; if (ready_cyc != LAT) begin fails++; $display("FAIL alt_latency got %0d want %0d", ready_cyc, LAT); end
  endtask

  task automatic test_reset_abort();
    bit to;
    int bad;
    int unsigned r;
    to = 1'b1;
    for (int k = 0; k < N; k++) flash_mem[k] = 8'($urandom);
    start_load();
    for (int i = 0; i < LAT; i++) begin
      if (wa_q.size() >= 300) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    tests++; if (to) begin fails++; $display("FAIL abort_reach_byte300 got %0d writes want 300", wa_q.size()); end
    r = $urandom_range(1, 14);
    repeat (r) tick();
    reset = 1'b1;
    tick();
    tests++; if (bus.spiCs !== 1'b1 || bus.spiCk !== 1'b0 || bus.w !== 1'b0) begin fails++; $display("FAIL abort_pins got cs=%b ck=%b w=%b want 1 0 0", bus.spiCs, bus.spiCk, bus.w); end
    tests++; if (wa_q.size() != 300) begin fails++; $display("FAIL abort_partial_write got %0d writes want 300", wa_q.size()); end
    clear_obs();
    reset = 1'b0;
    wait_ready(to);
    bad = count_bad_writes();
    tests++; if (to) begin fails++; $display("FAIL reload_ready_timeout got none want ready by %0d", LAT); end
    tests++; if (wa_q.size() != N || bad != 0) begin fails++; $display("FAIL reload_writes got count=%0d bad=%0d want count=%0d bad=0", wa_q.size(), bad, N); end
    tests++; if (ready_cyc != LAT) begin fails++; $display("FAIL reload_latency got %0d want %0d", ready_cyc, LAT); end
    tests++; if (viol_ww + viol_ckcs + viol_rdy != 0) begin fails++; $display("FAIL reload_protocol got ww=%0d ckcs=%0d rdy=%0d want 0", viol_ww, viol_ckcs, viol_rdy); end
  endtask

  initial begin
    bus.spiDi = 1'b0;
    test_reset();
    test_random_load();
    test_done_quiet();
    test_alternating();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rom_boot_loader.md
ROM_BOOT_LOADER -- requirements
Module: rom_boot_loader

Interface
REQ-001 The block SHALL have parameter KB, default 64, meaning ROM image size in KiB; N = KB*1024 bytes loaded.
REQ-002 The block SHALL have parameter OFFSET, default 24'h000000, meaning SPI flash byte address of the first image byte.
REQ-003 The block SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port spiCs, output, 1, flash chip select, active low.
REQ-006 The block SHALL have port spiCk, output, 1, flash serial clock, SPI mode 0.
REQ-007 The block SHALL have port spiDo, output, 1, master-out data to flash.
REQ-008 The block SHALL have port spiDi, input, 1, master-in data from flash.
REQ-009 The block SHALL have port a, output, $clog2(KB*1024), ROM write address.
REQ-010 The block SHALL have port d, output, 8, ROM write data.
REQ-011 The block SHALL have port w, output, 1, ROM write strobe, one clock wide per byte.
REQ-012 The block SHALL have port ready, output, 1, image fully written; CPU may be released.

Function
REQ-013 States SHALL be IDLE, CMD, ADDR, DUMMY (macro only), DATA, DONE.
REQ-014 IDLE SHALL last exactly one clock after reset deasserts, then enter CMD with spiCs low.
REQ-015 Each SPI bit SHALL take 2 clocks: phase 0 spiCk=0 with spiDo driven; phase 1 spiCk=1; spiDi sampled at the edge ending phase 1.
REQ-016 Bits SHALL be sent and received MSB first; one byte = 16 clocks.
REQ-017 CMD SHALL shift out the read opcode (8 bits), then ADDR SHALL shift out OFFSET (24 bits, MSB first).
REQ-018 In DATA spiDo SHALL be 0; N bytes SHALL be received back-to-back with no gap clocks.
REQ-019 On the edge completing byte k (0..N-1), a SHALL become k, d SHALL become that byte, w SHALL be 1 for exactly that one clock.
REQ-020 After byte N-1, spiCs SHALL go high and spiCk low on the same edge that asserts the final w; the state SHALL become DONE.
REQ-021 ready SHALL rise on the clock after the final w and stay high until reset; no further SPI activity or writes SHALL occur in DONE.
REQ-022 Without the macro, ready SHALL rise exactly 16*(4+N)+2 clocks after the first clock edge with reset low.
REQ-023 Internal byte counter SHALL be $clog2(N)+1 bits so the N-1 to N transition is detected without wrap to 0.
REQ-024 spiCs SHALL be high whenever spiCk toggles are not in progress; spiCk SHALL be low whenever spiCs is high.

Reset
REQ-025 While reset is high: spiCs=1, spiCk=0, spiDo=0, a=0, d=0, w=0, ready=0, state=IDLE.
REQ-026 Reset asserted mid-transfer SHALL abort at that edge (spiCs high, no partial-byte write) and a full reload from byte 0 SHALL follow release.

Configuration
REQ-027 Macro ROM_FAST_READ_EN SHALL select the flash read command.
REQ-028 With ROM_FAST_READ_EN defined: opcode 8'h0B, then DUMMY state of 8 bits (16 clocks, spiDo=0, spiDi ignored) between ADDR and DATA; ready latency 16*(5+N)+2.
REQ-029 Without ROM_FAST_READ_EN: opcode 8'h03, no DUMMY state, latency per REQ-022.

Verification
REQ-030 KB=1, OFFSET=0, no macro, flash model returns byte k = k[7:0] -> spiDo bits 8'h03,24'h000000; 1024 writes with a=k, d=k[7:0]; ready at clock 16450.
REQ-031 Same with ROM_FAST_READ_EN -> opcode 8'h0B, 16 dummy clocks, identical write data, ready at clock 16466.
REQ-032 OFFSET=24'h010000, model returns 8'hA5 then 8'h5A alternating -> address bits match 24'h010000; even a gets A5, odd a gets 5A.
REQ-033 Reset pulsed 1 clock during byte 300 -> spiCs high next edge, no w for byte 300, transfer restarts with a=0, ready only after full reload.
REQ-034 Every clock checks: w never 2 clocks in a row, spiCk low while spiCs high, ready never falls without reset, exactly N w pulses per load.
